// File: rtl/fft_frame_stream_io.sv
// Frame adapter around a radix-2 FFT core: serial samples in, parallel frame to core,
// PIPE_LAT-cycle token tracking, captured bins streamed out in natural or bit-reversed order.
module fft_frame_stream_io #(
  parameter int N_POINTS = 32,
  parameter int IN_W     = 8,
  parameter int OUT_W    = 16,
  parameter int PIPE_LAT = 6,
  localparam int LOG2N   = $clog2(N_POINTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      bitrev_mode,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_W-1:0]           s_data,
  output logic [N_POINTS*IN_W-1:0]  core_frame,
  output logic                      core_frame_stb,
  input  logic [N_POINTS*OUT_W-1:0] core_re,
  input  logic [N_POINTS*OUT_W-1:0] core_im,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [2*OUT_W-1:0]        m_data,
  output logic [LOG2N-1:0]          m_index,
  output logic                      m_last,
  output logic                      ovf,
  output logic [7:0]                drop_cnt
);

  typedef enum logic {ST_EMPTY, ST_STREAM} state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  logic                      s_ready_q;
  logic [LOG2N-1:0]          wr_cnt_q, wr_cnt_d;
  logic [N_POINTS*IN_W-1:0]  shadow_q, shadow_d;
  logic [N_POINTS*IN_W-1:0]  frame_q, frame_d;
  logic                      stb_q, stb_d;
  logic                      accept;
  logic                      cap_raw, cap;

  state_t                    state_q, state_d;
  logic [LOG2N-1:0]          rd_cnt_q, rd_cnt_d;
  logic                      brev_q, brev_d;
  logic [N_POINTS*OUT_W-1:0] re_buf_q, re_buf_d;
  logic [N_POINTS*OUT_W-1:0] im_buf_q, im_buf_d;
  logic                      ovf_q, ovf_d;
  logic [7:0]                drop_q, drop_d;
  logic                      last_beat;
  logic [LOG2N-1:0]          idx;

  // The completing sample is merged into shadow_d first so the frame copy sees all N samples.
  always_comb begin
    accept   = s_valid & s_ready_q & ~flush;
    wr_cnt_d = wr_cnt_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    stb_d    = 1'b0;
    if (flush) begin
      wr_cnt_d = '0;
    end else if (accept) begin
      shadow_d[wr_cnt_q*IN_W +: IN_W] = s_data;
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == LAST_IDX) begin
        frame_d = shadow_d;
        stb_d   = 1'b1;
      end
    end
  end

  if (PIPE_LAT == 1) begin : g_lat1
    assign cap_raw = stb_q;
  end else begin : g_latn
    logic [PIPE_LAT-2:0] tok_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tok_q <= '0;
      end else if (flush) begin
        tok_q <= '0;
      end else begin
        tok_q <= (tok_q << 1) | (PIPE_LAT-1)'(stb_q);
      end
    end
    assign cap_raw = tok_q[PIPE_LAT-2];
  end

  assign cap = cap_raw & ~flush;

  // A capture landing on the final accepted beat reloads directly, avoiding an idle cycle.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    brev_d    = brev_q;
    re_buf_d  = re_buf_q;
    im_buf_d  = im_buf_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    last_beat = (state_q == ST_STREAM) & m_ready & (rd_cnt_q == LAST_IDX);
    if (flush) begin
      state_d  = ST_EMPTY;
      rd_cnt_d = '0;
      brev_d   = 1'b0;
      re_buf_d = '0;
      im_buf_d = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if ((state_q == ST_STREAM) && m_ready) begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (last_beat) state_d = ST_EMPTY;
      end
      if (cap) begin
        if ((state_q == ST_EMPTY) || last_beat) begin
          state_d  = ST_STREAM;
          rd_cnt_d = '0;
          brev_d   = bitrev_mode;
          re_buf_d = core_re;
          im_buf_d = core_im;
        end else begin
          ovf_d = 1'b1;
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready_q <= 1'b0;
      wr_cnt_q  <= '0;
      shadow_q  <= '0;
      frame_q   <= '0;
      stb_q     <= 1'b0;
      state_q   <= ST_EMPTY;
      rd_cnt_q  <= '0;
      brev_q    <= 1'b0;
      re_buf_q  <= '0;
      im_buf_q  <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      s_ready_q <= en & ~flush;
      wr_cnt_q  <= wr_cnt_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_d;
      stb_q     <= stb_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      brev_q    <= brev_d;
      re_buf_q  <= re_buf_d;
      im_buf_q  <= im_buf_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign idx            = brev_q ? bit_rev(rd_cnt_q) : rd_cnt_q;
  assign s_ready        = s_ready_q;
  assign core_frame     = frame_q;
  assign core_frame_stb = stb_q;
  assign m_valid        = (state_q == ST_STREAM);
  assign m_index        = idx;
  assign m_data         = {re_buf_q[idx*OUT_W +: OUT_W], im_buf_q[idx*OUT_W +: OUT_W]};
  assign m_last         = m_valid & (rd_cnt_q == LAST_IDX);
  assign ovf            = ovf_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_fft_frame_stream_io.sv
// Bench for fft_frame_stream_io: directed steps plus a random phase, checked every cycle
// against a frame/token/beat-level reference model and a scheduled core model.
module tb_fft_frame_stream_io;

  localparam int N     = 32;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int LAT   = 6;
  localparam int LOG2N = 5;

  logic                   clk = 1'b0;
  logic                   rst, en, flush, bitrev_mode, s_valid, m_ready;
  logic [IN_W-1:0]        s_data;
  logic                   s_ready, core_frame_stb, m_valid, m_last, ovf;
  logic [N*IN_W-1:0]      core_frame;
  logic [N*OUT_W-1:0]     core_re, core_im;
  logic [2*OUT_W-1:0]     m_data;
  logic [LOG2N-1:0]       m_index;
  logic [7:0]             drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_frame_stream_io #(.N_POINTS(N), .IN_W(IN_W), .OUT_W(OUT_W), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .bitrev_mode(bitrev_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_frame(core_frame), .core_frame_stb(core_frame_stb),
    .core_re(core_re), .core_im(core_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int                 cap_at;
    logic [N*OUT_W-1:0] re;
    logic [N*OUT_W-1:0] im;
  } tok_t;

  tok_t               tq[$];
  logic [IN_W-1:0]    part[N];
  int                 cnt;
  logic [N*IN_W-1:0]  e_frame;
  bit                 e_stb, e_sready;
  bit                 strm, cur_brev;
  int                 pos;
  logic [N*OUT_W-1:0] cur_re, cur_im;
  bit                 e_ovf;
  int                 e_drop;
  int                 ncyc = 0;
  int                 core_mode = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic mdl_reset();
    cnt = 0; e_frame = '0; e_stb = 0; e_sready = 0; tq.delete();
    strm = 0; pos = 0; cur_brev = 0; e_ovf = 0; e_drop = 0;
  endtask

  // Model state after each negedge describes the DUT after the following rising edge.
  always @(negedge clk) begin
    int   ix;
    tok_t t;
    ncyc++;
    if (!rst) mdl_reset();
    chk("s_ready", 512'(s_ready), 512'(e_sready));
    chk("core_frame_stb", 512'(core_frame_stb), 512'(e_stb));
    chk("core_frame", 512'(core_frame), 512'(e_frame));
    chk("m_valid", 512'(m_valid), 512'(strm));
    if (strm) begin
      ix = cur_brev ? rev(pos) : pos;
      chk("m_index", 512'(m_index), 512'(ix));
      chk("m_data", 512'(m_data), 512'({cur_re[ix*OUT_W +: OUT_W], cur_im[ix*OUT_W +: OUT_W]}));
      chk("m_last", 512'(m_last), 512'(pos == N - 1));
    end else begin
      chk("m_last_idle", 512'(m_last), 512'(0));
    end
    chk("ovf", 512'(ovf), 512'(e_ovf));
    chk("drop_cnt", 512'(drop_cnt), 512'(e_drop));

    for (int w = 0; w < N * OUT_W / 32; w++) begin
      core_re[w*32 +: 32] = $urandom;
      core_im[w*32 +: 32] = $urandom;
    end
    if (rst && tq.size() > 0 && tq[0].cap_at == ncyc + 1) begin
      core_re = tq[0].re;
      core_im = tq[0].im;
    end

    if (rst) begin
      if (flush) begin
        cnt = 0; e_stb = 0; tq.delete(); strm = 0; pos = 0; e_ovf = 0; e_drop = 0;
      end else begin
        e_stb = 0;
        if (s_valid && e_sready) begin
          part[cnt] = s_data;
          cnt++;
          if (cnt == N) begin
            for (int k = 0; k < N; k++) e_frame[k*IN_W +: IN_W] = part[k];
            e_stb = 1;
            cnt = 0;
            t.cap_at = ncyc + 1 + LAT;
            for (int k = 0; k < N; k++) begin
              case (core_mode)
                1: begin t.re[k*OUT_W +: OUT_W] = 16'h0400; t.im[k*OUT_W +: OUT_W] = 16'h0000; end
                2: begin t.re[k*OUT_W +: OUT_W] = OUT_W'(k); t.im[k*OUT_W +: OUT_W] = OUT_W'(k); end
                default: begin
                  t.re[k*OUT_W +: OUT_W] = OUT_W'($urandom);
                  t.im[k*OUT_W +: OUT_W] = OUT_W'($urandom);
                end
              endcase
            end
            tq.push_back(t);
          end
        end
        if (strm && m_ready) begin
          pos++;
          if (pos == N) begin strm = 0; pos = 0; end
        end
        if (tq.size() > 0 && tq[0].cap_at == ncyc + 1) begin
          t = tq.pop_front();
          if (!strm) begin
            strm = 1; pos = 0; cur_re = t.re; cur_im = t.im; cur_brev = bitrev_mode;
          end else begin
            e_ovf = 1;
            if (e_drop < 255) e_drop++;
          end
        end
      end
      e_sready = en & ~flush;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [IN_W-1:0] d);
    bit got = 0;
    s_valid = 1; s_data = d;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk); got = s_ready;
      @(posedge clk); #1;
    end
    chk("push_accept", 512'(got), 512'(1));
  endtask

  task automatic wait_pos(input int p);
    for (int t = 0; t < 300 && !(strm && pos == p); t++) step(1);
    chk("reach_beat", 512'(strm && (pos == p)), 512'(1));
  endtask

  initial begin
    rst = 1; en = 0; flush = 0; bitrev_mode = 0; s_valid = 0; s_data = '0; m_ready = 0;
    core_re = '0; core_im = '0;
    mdl_reset();
    #1 rst = 0;
    #2;
    chk("rst_s_ready", 512'(s_ready), 512'(0));
    chk("rst_stb", 512'(core_frame_stb), 512'(0));
    chk("rst_core_frame", 512'(core_frame), 512'(0));
    chk("rst_m_valid", 512'(m_valid), 512'(0));
    chk("rst_m_data", 512'(m_data), 512'(0));
    chk("rst_m_index", 512'(m_index), 512'(0));
    chk("rst_ovf", 512'(ovf), 512'(0));
    chk("rst_drop", 512'(drop_cnt), 512'(0));
    en = 1;
    step(3);
    rst = 1;
    step(1);
    chk("s_ready_rise", 512'(s_ready), 512'(1));

    // T1 impulse
    core_mode = 1; m_ready = 1;
    push(8'h01);
    for (int i = 1; i < N; i++) push(8'h00);
    s_valid = 0;
    step(LAT + N + 5);
    chk("t1_ovf", 512'(ovf), 512'(0));

    // T2 back-to-back
    core_mode = 0;
    for (int i = 0; i < 4 * N; i++) push(IN_W'($urandom));
    s_valid = 0;
    step(LAT + N + 5);
    chk("t2_ovf", 512'(ovf), 512'(0));

    // T3 bit-reversed, mode toggled mid-stream
    core_mode = 2; bitrev_mode = 1;
    for (int i = 0; i < N; i++) push(IN_W'(i));
    s_valid = 0;
    wait_pos(5);
    bitrev_mode = 0;
    step(N + 5);

    // T4 overflow
    core_mode = 0; m_ready = 0;
    for (int i = 0; i < 2 * N; i++) push(IN_W'($urandom));
    s_valid = 0;
    step(LAT + 3);
    chk("t4_ovf", 512'(ovf), 512'(1));
    chk("t4_drop", 512'(drop_cnt), 512'(1));
    m_ready = 1;
    step(N + 5);
    chk("t4_drained", 512'(m_valid), 512'(0));
    chk("t4_ovf_sticky", 512'(ovf), 512'(1));

    // random traffic with backpressure and enable gaps
    for (int c = 0; c < 600; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = IN_W'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 15) != 0);
      bitrev_mode = 1'($urandom_range(0, 1));
      step(1);
    end
    s_valid = 0; en = 1; m_ready = 1; bitrev_mode = 0;
    flush = 1; step(1); flush = 0;
    step(LAT + N + 5);

    // T5 pause then flush
    for (int i = 0; i < 10; i++) push(IN_W'($urandom));
    s_valid = 0; en = 0;
    step(5);
    chk("t5_paused", 512'(s_ready), 512'(0));
    en = 1;
    for (int i = 0; i < N - 10; i++) push(IN_W'($urandom));
    s_valid = 0;
    step(LAT + N + 5);
    for (int i = 0; i < 12; i++) push(IN_W'($urandom));
    flush = 1; s_valid = 1;
    step(1);
    flush = 0; s_valid = 0;
    for (int i = 0; i < N; i++) push(IN_W'($urandom));
    s_valid = 0;
    step(LAT + N + 5);
    chk("t5_ovf", 512'(ovf), 512'(0));
    chk("t5_drop", 512'(drop_cnt), 512'(0));

    // T6 async reset during output beat 12
    for (int i = 0; i < N; i++) push(IN_W'($urandom));
    s_valid = 0;
    wait_pos(12);
    #1 rst = 0;
    #1;
    chk("t6_m_valid", 512'(m_valid), 512'(0));
    chk("t6_s_ready", 512'(s_ready), 512'(0));
    chk("t6_stb", 512'(core_frame_stb), 512'(0));
    chk("t6_ovf", 512'(ovf), 512'(0));
    chk("t6_core_frame", 512'(core_frame), 512'(0));
    step(2);
    rst = 1;
    for (int i = 0; i < N; i++) push(IN_W'($urandom));
    s_valid = 0;
    step(LAT + N + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
